// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 clock, then
// shifts in 11-bit frames on falling edges, with parity/framing checks and an inter-edge timeout.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2d,
    input  logic       i_ps2c,
    input  logic       i_rx_en,
    output logic       o_rx_done_tick,
    output logic [7:0] o_dout,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_timeout_tick
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;

    logic [1:0]            c_sync_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  fclk_q, fclk_d, fall_tick;
    state_t                state_q;
    logic [3:0]            bcnt_q;
    logic [TW-1:0]         tmo_q;
    logic [10:0]           frame_q, frame_d;
    logic [7:0]            dout_q;
    logic                  perr_q, ferr_q, done_q, tmo_tick_q;

    // Filtered clock only moves once the whole window agrees; mixed windows hold.
    always_comb begin
        fclk_d = fclk_q;
        if (&filt_q)
            fclk_d = 1'b1;
        else if (~|filt_q)
            fclk_d = 1'b0;
        fall_tick = fclk_q & ~fclk_d;
        frame_d   = {d_sync_q[1], frame_q[10:1]};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            filt_q   <= '1;
            fclk_q   <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[0], i_ps2c};
            d_sync_q <= {d_sync_q[0], i_ps2d};
            filt_q   <= {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
            fclk_q   <= fclk_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            tmo_q      <= '0;
            frame_q    <= '0;
            dout_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_tick_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            tmo_tick_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fall_tick && i_rx_en) begin
                        frame_q <= frame_d;
                        bcnt_q  <= 4'd9;
                        tmo_q   <= '0;
                        state_q <= DPS;
                    end
                end
                DPS: begin
                    if (fall_tick) begin
                        frame_q <= frame_d;
                        tmo_q   <= '0;
                        if (bcnt_q == 4'd0) begin
                            // Outputs are taken from the frame including the bit arriving now.
                            state_q <= LOAD;
                            dout_q  <= frame_d[8:1];
                            perr_q  <= ~^frame_d[9:1];
                            ferr_q  <= frame_d[0] | ~frame_d[10];
                            done_q  <= 1'b1;
                        end else begin
                            bcnt_q <= bcnt_q - 4'd1;
                        end
                    end else if (tmo_q == TMO_MAX) begin
                        tmo_q      <= '0;
                        tmo_tick_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                LOAD:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_rx_done_tick = done_q;
    assign o_timeout_tick = tmo_tick_q;
    assign o_dout         = dout_q;
    assign o_parity_err   = perr_q;
    assign o_frame_err    = ferr_q;
endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: clean, back-to-back, errored, glitched, timed-out,
// reset-interrupted and disabled frames, checked against hand-computed values.
module tb_ps2_rx;
    localparam int FL   = 8;
    localparam int TMO  = 500;
    localparam int HALF = 40;

    logic       clk = 1'b0, rst = 1'b1, ps2d = 1'b1, ps2c = 1'b1, rx_en = 1'b1;
    logic       done, perr, ferr, tmo_tick;
    logic [7:0] dout;

    int n_tests = 0, n_fail = 0;
    int done_cnt = 0, tmo_cnt = 0, both_cnt = 0;
    logic [7:0] dq[$];
    logic       peq[$], feq[$];

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset(rst), .i_ps2d(ps2d), .i_ps2c(ps2c), .i_rx_en(rx_en),
        .o_rx_done_tick(done), .o_dout(dout), .o_parity_err(perr),
        .o_frame_err(ferr), .o_timeout_tick(tmo_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            dq.push_back(dout);
            peq.push_back(perr);
            feq.push_back(ferr);
        end
        if (tmo_tick) tmo_cnt++;
        if (done && tmo_tick) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    // Sends the first nbits of fr LSB first; data changes while ps2c is high.
    task automatic send_bits(input logic [10:0] fr, input int nbits, input bit glitch, input int drop_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == drop_at) rx_en = 1'b0;
            ps2d = fr[i];
            if (glitch) begin
                tick(15); ps2c = 1'b0; tick(3); ps2c = 1'b1; tick(HALF - 18);
            end else begin
                tick(HALF);
            end
            ps2c = 1'b0;
            tick(HALF);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        tick(HALF);
    endtask

    int d0, t0, q0;

    initial begin
        tick(4);
        rst = 1'b0;
        tick(2);
        chk("rst_dout", dout, 8'h00);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", tmo_tick, 0);

        // clean 0x1C, odd parity bit 0
        d0 = done_cnt; q0 = dq.size();
        send_bits(mkframe(8'h1C, 1'b0, 1'b1), 11, 0, -1);
        tick(20);
        chk("c1_ticks", done_cnt - d0, 1);
        chk("c1_dout", (dq.size() > q0) ? dq[q0] : 8'hxx, 8'h1C);
        chk("c1_perr", perr, 0);
        chk("c1_ferr", ferr, 0);

        // back-to-back 0xF0, 0x5A
        d0 = done_cnt; q0 = dq.size();
        send_bits(mkframe(8'hF0, 1'b1, 1'b1), 11, 0, -1);
        send_bits(mkframe(8'h5A, 1'b1, 1'b1), 11, 0, -1);
        tick(20);
        chk("b2b_ticks", done_cnt - d0, 2);
        chk("b2b_d0", (dq.size() > q0) ? dq[q0] : 8'hxx, 8'hF0);
        chk("b2b_d1", (dq.size() > q0 + 1) ? dq[q0+1] : 8'hxx, 8'h5A);
        chk("b2b_err0", (peq.size() > q0) ? {peq[q0], feq[q0]} : 2'bxx, 2'b00);
        chk("b2b_err1", {perr, ferr}, 2'b00);

        // bad parity and bad stop still deliver data
        d0 = done_cnt;
        send_bits(mkframe(8'h1C, 1'b1, 1'b0), 11, 0, -1);
        tick(20);
        chk("err_ticks", done_cnt - d0, 1);
        chk("err_dout", dout, 8'h1C);
        chk("err_perr", perr, 1);
        chk("err_ferr", ferr, 1);

        // 3-cycle low glitches in every high phase
        d0 = done_cnt;
        send_bits(mkframe(8'h1C, 1'b0, 1'b1), 11, 1, -1);
        tick(20);
        chk("gl_ticks", done_cnt - d0, 1);
        chk("gl_dout", dout, 8'h1C);
        chk("gl_err", {perr, ferr}, 2'b00);

        // partial frame abandoned by timeout
        d0 = done_cnt; t0 = tmo_cnt;
        send_bits(mkframe(8'h5A, 1'b1, 1'b1), 5, 0, -1);
        tick(TMO + 100);
        chk("to_tmo", tmo_cnt - t0, 1);
        chk("to_done", done_cnt - d0, 0);
        chk("to_dout", dout, 8'h1C);
        d0 = done_cnt;
        send_bits(mkframe(8'h5A, 1'b1, 1'b1), 11, 0, -1);
        tick(20);
        chk("to_next_ticks", done_cnt - d0, 1);
        chk("to_next_dout", dout, 8'h5A);

        // rx_en dropped mid-frame does not abort it
        d0 = done_cnt;
        send_bits(mkframe(8'hF0, 1'b1, 1'b1), 11, 0, 4);
        tick(20);
        chk("en_drop_ticks", done_cnt - d0, 1);
        chk("en_drop_dout", dout, 8'hF0);
        rx_en = 1'b1;

        // reset mid-frame, then 0xF0
        d0 = done_cnt; t0 = tmo_cnt;
        send_bits(mkframe(8'h5A, 1'b1, 1'b1), 6, 0, -1);
        rst = 1'b1; tick(2); rst = 1'b0;
        tick(TMO + 100);
        chk("rst_mid_done", done_cnt - d0, 0);
        chk("rst_mid_tmo", tmo_cnt - t0, 0);
        chk("rst_mid_dout", dout, 8'h00);
        send_bits(mkframe(8'hF0, 1'b1, 1'b1), 11, 0, -1);
        tick(20);
        chk("rst_f0_ticks", done_cnt - d0, 1);
        chk("rst_f0_dout", dout, 8'hF0);

        // disabled receiver ignores a whole frame
        d0 = done_cnt; t0 = tmo_cnt;
        rx_en = 1'b0;
        send_bits(mkframe(8'h5A, 1'b1, 1'b1), 11, 0, -1);
        tick(TMO + 100);
        chk("dis_done", done_cnt - d0, 0);
        chk("dis_tmo", tmo_cnt - t0, 0);
        chk("dis_dout", dout, 8'hF0);

        chk("tick_overlap", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized PS2 clock samples required to change the filtered clock level.
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: i_clk cycles allowed between falling edges inside a frame (2 ms at 100 MHz).
REQ-003 i_clk  input  1  system clock (100 MHz); sole clock domain.
REQ-004 i_reset  input  1  reset; synchronous, active-high.
REQ-005 i_ps2d  input  1  raw PS/2 data line, asynchronous.
REQ-006 i_ps2c  input  1  raw PS/2 clock line, asynchronous.
REQ-007 i_rx_en  input  1  receive enable; a new frame starts only while high.
REQ-008 o_rx_done_tick  output  1  one-cycle pulse; a full frame has been received.
REQ-009 o_dout  output  8  received data byte, LSB first on wire.
REQ-010 o_parity_err  output  1  received frame failed odd parity.
REQ-011 o_frame_err  output  1  received frame had start != 0 or stop != 1.
REQ-012 o_timeout_tick  output  1  one-cycle pulse; a partial frame was abandoned.

Function
REQ-013 i_ps2c and i_ps2d each pass through a 2-flop synchronizer before any other use.
REQ-014 Filter: FILTER_LEN-bit shift register of synchronized ps2c; filtered clock -> 1 when all bits 1, -> 0 when all bits 0, otherwise holds.
REQ-015 fall_tick is high for exactly one cycle when filtered clock transitions 1->0; synchronized ps2d is sampled in that cycle.
REQ-016 A clean raw ps2c falling edge produces fall_tick within FILTER_LEN+3 cycles; a ps2c low or high glitch shorter than FILTER_LEN cycles produces no fall_tick.
REQ-017 FSM states: IDLE, DPS (data/parity/stop), LOAD.
REQ-018 IDLE: on fall_tick with i_rx_en=1, shift sampled bit (start) into 11-bit frame register, load bit counter = 9, clear timeout counter, go DPS; fall_tick with i_rx_en=0 is ignored.
REQ-019 DPS: on each fall_tick shift sampled bit in (LSB-first, shift right), clear timeout counter; if bit counter = 0 go LOAD, else decrement.
REQ-020 DPS: without fall_tick, timeout counter increments; on reaching TIMEOUT_CYCLES-1, discard frame, pulse o_timeout_tick one cycle, go IDLE; o_dout and error flags unchanged.
REQ-021 i_rx_en deasserted during DPS does not abort the frame.
REQ-022 Frame register after 11 bits: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
REQ-023 On the edge entering LOAD, register o_dout = frame[8:1], o_parity_err = ~^frame[9:1] (error when ones count in data+parity is even), o_frame_err = frame[0] | ~frame[10].
REQ-024 LOAD lasts exactly one cycle; o_rx_done_tick = 1 only in LOAD; next state IDLE unconditionally; fall_ticks during LOAD are ignored.
REQ-025 o_dout, o_parity_err, o_frame_err hold their values until the next LOAD; a frame with errors still delivers o_rx_done_tick and data.
REQ-026 o_rx_done_tick and o_timeout_tick are never high in the same cycle.

Reset
REQ-027 i_reset=1 at a rising i_clk edge forces: state IDLE, bit/timeout counters 0, frame register 0, filter register all ones, filtered clock 1, synchronizers 1, o_dout=0x00, o_parity_err=0, o_frame_err=0, o_rx_done_tick=0, o_timeout_tick=0.
REQ-028 Reset mid-frame discards the partial frame with no tick of either kind; the first falling edge after release is treated as a start bit.

Verification
REQ-029 Frame 0x1C (start 0, data 0x1C, parity 0, stop 1) at 12.5 kHz ps2c, i_rx_en=1 -> one o_rx_done_tick, o_dout=0x1C, both error flags 0.
REQ-030 Frame 0xF0 then 0x5A back-to-back, parity 1 each -> two ticks, o_dout=0xF0 then 0x5A, no errors.
REQ-031 Frame 0x1C with parity 1 and stop 0 -> tick, o_dout=0x1C, o_parity_err=1, o_frame_err=1.
REQ-032 FILTER_LEN=8: 3-cycle ps2c low glitches inserted between bits of 0x1C -> o_dout=0x1C, exactly one tick.
REQ-033 5 bits sent then ps2c held high for TIMEOUT_CYCLES -> one o_timeout_tick, no done tick, o_dout unchanged; following frame 0x5A received correctly.
REQ-034 i_reset pulsed after 6 bits, then full frame 0xF0; and separately frame sent with i_rx_en=0 -> only 0xF0 received, no tick for the disabled frame.
